baccarat_datapath: RTL



---
 rtl/baccarat_pkg.sv | 39 +++
 rtl/baccarat_datapath_scorehand.sv | 28 ++
 rtl/baccarat_datapath.sv | 74 +++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat game blocks.
// Contents:
//   card_t            4-bit card code (0 = empty, 1 = ace ... 13 = king)
//   CARD_* constants  named card codes
//   state_t           statemachine state encoding, shared with the datapath
//   card_value()      baccarat point value of a card code
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_TEN   = 4'd10;
    localparam card_t CARD_JACK  = 4'd11;
    localparam card_t CARD_QUEEN = 4'd12;
    localparam card_t CARD_KING  = 4'd13;

    typedef enum logic [3:0] {
        DEAL_PCARD1        = 4'd0,
        DEAL_DCARD1        = 4'd1,
        DEAL_PCARD2        = 4'd2,
        DEAL_DCARD2        = 4'd3,
        THIRDCARD_DECISION = 4'd4,
        DEAL_PCARD3        = 4'd5,
        DEALER_DECISION    = 4'd6,
        DEAL_DCARD3        = 4'd7,
        WINNER_DECISION    = 4'd8
    } state_t;

    // Ace through nine count at face value; ten, court cards and an
    // empty slot all count zero.
    function automatic logic [3:0] card_value(input card_t code);
        if (code >= CARD_ACE && code < CARD_TEN) begin
            return code;
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/baccarat_datapath_scorehand.sv
// Combinational baccarat hand scorer.
// Ports:
//   card1, card2, card3  in   card codes of one hand (0 = empty slot)
//   score                out  (sum of card values) mod 10, range 0..9
module scorehand
    import baccarat_pkg::*;
(
    input  card_t      card1,
    input  card_t      card2,
    input  card_t      card3,
    output logic [3:0] score
);

    logic [4:0] sum;

    always_comb begin
        sum = 5'(card_value(card1)) + 5'(card_value(card2)) + 5'(card_value(card3));
        // Sum never exceeds 27, so mod 10 is at most two tens removed.
        if (sum >= 5'd20) begin
            score = 4'(sum - 5'd20);
        end else if (sum >= 5'd10) begin
            score = 4'(sum - 5'd10);
        end else begin
            score = sum[3:0];
        end
    end

endmodule

// File: rtl/baccarat_datapath.sv
// Card-dealing and scoring datapath for the baccarat game.
// A free-running counter supplies the next card; six registers capture it
// on their load strobes; two scorers produce the hand scores.
// Ports:
//   slow_clock           in   game clock, rising edge
//   resetb               in   synchronous active-high reset
//   load_pcard1..3       in   capture new_card into the player slots
//   load_dcard1..3       in   capture new_card into the dealer slots
//   pcard1..3, dcard1..3 out  card codes held, 0 = empty
//   pscore, dscore       out  hand scores 0..9 (combinational from cards)
//   new_card             out  card dealt at the next edge
module baccarat_datapath
    import baccarat_pkg::*;
#(
    parameter int CARD_MAX = 13
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] new_card
);

    localparam card_t CARD_LAST = card_t'(CARD_MAX);

    // Counter advances on every non-reset edge regardless of loads; all
    // registers loaded on the same edge see the same pre-edge card.
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            new_card <= CARD_ACE;
            pcard1   <= CARD_EMPTY;
            pcard2   <= CARD_EMPTY;
            pcard3   <= CARD_EMPTY;
            dcard1   <= CARD_EMPTY;
            dcard2   <= CARD_EMPTY;
            dcard3   <= CARD_EMPTY;
        end else begin
            new_card <= (new_card == CARD_LAST) ? CARD_ACE : new_card + 4'd1;
            if (load_pcard1) pcard1 <= new_card;
            if (load_pcard2) pcard2 <= new_card;
            if (load_pcard3) pcard3 <= new_card;
            if (load_dcard1) dcard1 <= new_card;
            if (load_dcard2) dcard2 <= new_card;
            if (load_dcard3) dcard3 <= new_card;
        end
    end

    scorehand u_player (
        .card1 (pcard1),
        .card2 (pcard2),
        .card3 (pcard3),
        .score (pscore)
    );

    scorehand u_dealer (
        .card1 (dcard1),
        .card2 (dcard2),
        .card3 (dcard3),
        .score (dscore)
    );

endmodule
